// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped countdown timer with a sticky pending flag and interrupt output.
// Define TIMER_PRESCALE_EN to add the PRESCALE register (offset 0x10) and tick prescaler.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int unsigned CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        irq
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_DONE} state_t;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESET   = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_STATUS   = 3'd3;
    localparam logic [2:0] OFF_PRESCALE = 3'd4;

    state_t           state_reg, state_next;
    logic             en_reg, en_next;
    logic             auto_reg, auto_next;
    logic             ie_reg, ie_next;
    logic             pending_reg, pending_next;
    logic [CNT_W-1:0] preset_reg, preset_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic wr_en, wr_ctrl, wr_preset, wr_count, wr_status;
    logic tick;
    logic unused_bits;

    assign hit       = (addr[31:5] == BASE_ADDR[31:5]);
    assign wr_en     = we & hit;
    assign wr_ctrl   = wr_en && (addr[4:2] == OFF_CTRL);
    assign wr_preset = wr_en && (addr[4:2] == OFF_PRESET);
    assign wr_count  = wr_en && (addr[4:2] == OFF_COUNT);
    assign wr_status = wr_en && (addr[4:2] == OFF_STATUS);

    // Byte-lane bits are ignored: registers are word-wide only.
    assign unused_bits = ^{addr[1:0], wdata};

    // irq is derived from registered state only, so bus address activity cannot glitch it.
    assign irq = pending_reg & ie_reg;

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale_reg, prescale_next;
    logic [15:0] psc_cnt_reg, psc_cnt_next;
    logic        wr_prescale;

    assign wr_prescale = wr_en && (addr[4:2] == OFF_PRESCALE);
    assign tick        = (psc_cnt_reg == prescale_reg);

    always_comb begin
        prescale_next = prescale_reg;
        psc_cnt_next  = psc_cnt_reg;
        if (wr_prescale)
            prescale_next = wdata[15:0];
        if (state_reg == S_LOAD)
            psc_cnt_next = 16'd0;
        else if (state_reg == S_CNT)
            psc_cnt_next = tick ? 16'd0 : psc_cnt_reg + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_reg <= 16'd0;
            psc_cnt_reg  <= 16'd0;
        end else begin
            prescale_reg <= prescale_next;
            psc_cnt_reg  <= psc_cnt_next;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_next   = state_reg;
        en_next      = en_reg;
        auto_next    = auto_reg;
        ie_next      = ie_reg;
        pending_next = pending_reg;
        preset_next  = preset_reg;
        count_next   = count_reg;

        // Clear is applied before the FSM so that a same-edge expiry in DONE wins.
        if (wr_status && wdata[0])
            pending_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (wr_ctrl && wdata[0])
                    state_next = S_LOAD;
            end
            S_LOAD: begin
                count_next = preset_reg;
                state_next = S_CNT;
            end
            S_CNT: begin
                if (count_reg == '0)
                    state_next = S_DONE;
                else if (tick)
                    count_next = count_reg - CNT_W'(1);
            end
            S_DONE: begin
                pending_next = 1'b1;
                if (auto_reg) begin
                    state_next = S_LOAD;
                end else begin
                    state_next = S_IDLE;
                    en_next    = 1'b0;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Disabling aborts the sequence in place; enabling mid-sequence only updates auto/ie.
        if (wr_ctrl) begin
            auto_next = wdata[1];
            ie_next   = wdata[2];
            if (!wdata[0]) begin
                state_next   = S_IDLE;
                en_next      = 1'b0;
                count_next   = count_reg;
                pending_next = pending_reg;
            end else if (state_reg == S_IDLE) begin
                en_next = 1'b1;
            end
        end

        if (wr_preset)
            preset_next = wdata[CNT_W-1:0];
        if (wr_count)
            count_next = wdata[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            en_reg      <= 1'b0;
            auto_reg    <= 1'b0;
            ie_reg      <= 1'b0;
            pending_reg <= 1'b0;
            preset_reg  <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            en_reg      <= en_next;
            auto_reg    <= auto_next;
            ie_reg      <= ie_next;
            pending_reg <= pending_next;
            preset_reg  <= preset_next;
            count_reg   <= count_next;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (addr[4:2])
                OFF_CTRL:     rdata = {29'd0, ie_reg, auto_reg, en_reg};
                OFF_PRESET:   rdata = 32'(preset_reg);
                OFF_COUNT:    rdata = 32'(count_reg);
                OFF_STATUS:   rdata = {31'd0, pending_reg};
`ifdef TIMER_PRESCALE_EN
                OFF_PRESCALE: rdata = {16'd0, prescale_reg};
`endif
                default:      rdata = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed timeline checks plus randomized bus traffic against a behavioural model.
// Honours TIMER_PRESCALE_EN the same way as the design.
module tb_mmio_timer;
    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_PRESET = BASE + 32'h04;
    localparam logic [31:0] A_COUNT = BASE + 32'h08;
    localparam logic [31:0] A_STATUS = BASE + 32'h0C;
    localparam logic [31:0] A_PRESCALE = BASE + 32'h10;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_LOAD = 2'd1;
    localparam logic [1:0] PH_CNT  = 2'd2;
    localparam logic [1:0] PH_DONE = 2'd3;

    typedef struct packed {
        logic [1:0]  phase;
        logic        en;
        logic        autorl;
        logic        ie;
        logic        pending;
        logic [31:0] preset;
        logic [31:0] count;
        logic [15:0] prescale;
        logic [15:0] psc;
    } model_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        we = 1'b0;
    logic        hit;
    logic [31:0] rdata;
    logic        irq;

    int     n_checks = 0;
    int     n_fail = 0;
    bit     chk_en = 1'b0;
    model_t m = '0;

    mmio_timer #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
        .hit(hit), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic bit in_window(logic [31:0] a);
        return a[31:5] == BASE[31:5];
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        logic [2:0] off;
        off = a[4:2];
        if (!in_window(a)) return 32'd0;
        case (off)
            3'd0: return {29'd0, m.ie, m.autorl, m.en};
            3'd1: return m.preset;
            3'd2: return m.count;
            3'd3: return {31'd0, m.pending};
`ifdef TIMER_PRESCALE_EN
            3'd4: return {16'd0, m.prescale};
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Next model state from the register map and timeline rules, given one bus cycle.
    function automatic model_t model_next(model_t o, logic [31:0] a, logic [31:0] d, logic w);
        model_t     n;
        logic       wr;
        logic [2:0] off;
        logic       tick;
        n = o;
        wr = w && in_window(a);
        off = a[4:2];
`ifdef TIMER_PRESCALE_EN
        tick = (o.psc == o.prescale);
`else
        tick = 1'b1;
`endif
        case (o.phase)
            PH_IDLE: if (wr && off == 3'd0 && d[0]) n.phase = PH_LOAD;
            PH_LOAD: begin n.count = o.preset; n.phase = PH_CNT; n.psc = 16'd0; end
            PH_CNT: begin
                if (o.count == 32'd0) n.phase = PH_DONE;
                else if (tick) n.count = o.count - 32'd1;
                n.psc = tick ? 16'd0 : o.psc + 16'd1;
            end
            default: begin
                n.pending = 1'b1;
                n.phase = o.autorl ? PH_LOAD : PH_IDLE;
                if (!o.autorl) n.en = 1'b0;
            end
        endcase
        if (wr) begin
            case (off)
                3'd0: begin
                    n.autorl = d[1];
                    n.ie = d[2];
                    if (!d[0]) begin
                        n.phase = PH_IDLE; n.en = 1'b0; n.count = o.count; n.pending = o.pending;
                    end else if (o.phase == PH_IDLE) begin
                        n.en = 1'b1;
                    end
                end
                3'd1: n.preset = d;
                3'd2: n.count = d;
                3'd3: if (d[0] && o.phase != PH_DONE) n.pending = 1'b0;
`ifdef TIMER_PRESCALE_EN
                3'd4: n.prescale = d[15:0];
`endif
                default: ;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else m <= model_next(m, addr, wdata, we);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("hit", 32'(hit), 32'(in_window(addr)));
            check("rdata", rdata, model_read(addr));
            check("irq", 32'(irq), 32'(m.pending & m.ie));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        step();
        we = 1'b0;
        $display("write addr=%08h data=%08h t=%0t", a, d, $time);
    endtask

    task automatic peek(string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int e;
        logic [31:0] a, d;
        int off;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;

        peek("rst_ctrl", A_CTRL, 32'd0);
        peek("rst_count", A_COUNT, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);

        // One-shot countdown, PRESET=5, ie=1.
        bus(A_PRESET, 32'd5);
        bus(A_CTRL, 32'h5);
        addr = A_COUNT;
        step();
        check("a_count_e1", rdata, 32'd5);
        repeat (5) step();
        check("a_count_e6", rdata, 32'd0);
        step();
        check("a_irq_e7", 32'(irq), 32'd0);
        step();
        check("a_irq_e8", 32'(irq), 32'd1);
        peek("a_ctrl_after", A_CTRL, 32'h4);
        peek("a_status", A_STATUS, 32'd1);
        bus(A_STATUS, 32'd1);
        check("a_irq_clr", 32'(irq), 32'd0);

        // Auto-reload, PRESET=3: pending at edges 6, 12, 18.
        bus(A_PRESET, 32'd3);
        bus(A_CTRL, 32'h7);
        e = 0;
        for (int p = 1; p <= 3; p++) begin
            while (e < 6 * p - 1) begin step(); e++; end
            check("b_irq_before", 32'(irq), 32'd0);
            step(); e++;
            check("b_irq_set", 32'(irq), 32'd1);
            bus(A_STATUS, 32'd1); e++;
            check("b_irq_clr", 32'(irq), 32'd0);
        end
        bus(A_CTRL, 32'h0);

        // STATUS clear coinciding with the DONE edge: set wins.
        bus(A_PRESET, 32'd5);
        bus(A_CTRL, 32'h5);
        repeat (7) step();
        peek("c_status_e7", A_STATUS, 32'd0);
        bus(A_STATUS, 32'd1);
        peek("c_status_e8", A_STATUS, 32'd1);
        check("c_irq_e8", 32'(irq), 32'd1);
        bus(A_STATUS, 32'd1);
        peek("c_status_clr", A_STATUS, 32'd0);

        // COUNT write during CNT overrides the decrement; disable holds COUNT.
        bus(A_PRESET, 32'd10);
        bus(A_CTRL, 32'h1);
        addr = A_COUNT;
        repeat (3) step();
        check("d_count_e3", rdata, 32'd8);
        bus(A_COUNT, 32'h20);
        check("d_count_wr", rdata, 32'h20);
        step();
        check("d_count_dec", rdata, 32'h1F);
        bus(A_CTRL, 32'h0);
        peek("d_count_hold", A_COUNT, 32'h1F);
        repeat (3) step();
        check("d_count_idle", rdata, 32'h1F);

        // Address decode.
        addr = BASE + 32'h20; wdata = 32'hFFFF_FFFF; we = 1'b1;
        #1;
        check("e_hit_out", 32'(hit), 32'd0);
        check("e_rdata_out", rdata, 32'd0);
        step();
        we = 1'b0;
        peek("e_count_b", BASE + 32'h0B, 32'h1F);
        peek("e_preset", A_PRESET, 32'd10);
        peek("e_ctrl", A_CTRL, 32'd0);
        bus(BASE + 32'h14, 32'hFFFF_FFFF);
        peek("e_unmapped", BASE + 32'h14, 32'd0);
`ifndef TIMER_PRESCALE_EN
        bus(A_PRESCALE, 32'hFFFF_FFFF);
        peek("e_no_prescale", A_PRESCALE, 32'd0);
`endif

        // Reset mid-count.
        bus(A_PRESET, 32'd100);
        bus(A_CTRL, 32'h5);
        addr = A_COUNT;
        repeat (61) step();
        check("f_count_40", rdata, 32'd40);
        #1;
        reset = 1'b1;
        #1;
        check("f_rst_count", rdata, 32'd0);
        check("f_rst_irq", 32'(irq), 32'd0);
        peek("f_rst_preset", A_PRESET, 32'd0);
        peek("f_rst_ctrl", A_CTRL, 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        repeat (120) step();
        peek("f_status_after", A_STATUS, 32'd0);
        peek("f_count_after", A_COUNT, 32'd0);

`ifdef TIMER_PRESCALE_EN
        // PRESCALE=2, PRESET=4: decrement every 3 cycles, pending at edge 15.
        bus(A_PRESCALE, 32'd2);
        bus(A_PRESET, 32'd4);
        bus(A_CTRL, 32'h5);
        addr = A_COUNT;
        repeat (3) step();
        check("g_count_e3", rdata, 32'd4);
        step();
        check("g_count_e4", rdata, 32'd3);
        repeat (10) step();
        check("g_irq_e14", 32'(irq), 32'd0);
        step();
        check("g_irq_e15", 32'(irq), 32'd1);
        bus(A_STATUS, 32'd1);
        bus(A_PRESCALE, 32'd0);
`endif

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            off = $urandom_range(0, 7);
            a = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) a = BASE ^ (32'h1 << $urandom_range(5, 31));
            d = $urandom;
            case (off)
                0: d[0] = ($urandom_range(0, 4) != 0);
                1: d = 32'($urandom_range(0, 6));
                2: d = 32'($urandom_range(0, 10));
                4: d = 32'($urandom_range(0, 3));
                default: ;
            endcase
            addr = a; wdata = d; we = ($urandom_range(0, 99) < 15);
            step();
            if (i % 1000 == 500) begin
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end
        we = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped countdown timer with interrupt generation. It sits on the CPU data bus, downstream of the single-cycle core. It consumes the core's store address, store data and write enable, and returns read data in the same cycle for loads. It drives the core's `INT` input when a programmed countdown expires.

## Interface
Parameters:
- `BASE_ADDR`, default `32'h0000_7F00`: byte base of the 32-byte register window; bits [4:0] must be zero.
- `CNT_W`, default `32`: width of COUNT and PRESET.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `addr`  in  32  CPU data address (core `Addr_out`).
- `wdata`  in  32  CPU store data (core `Data_out`).
- `we`  in  1  CPU store enable (core `DMWr`).
- `hit`  out  1  combinational; `addr[31:5] == BASE_ADDR[31:5]`.
- `rdata`  out  32  combinational read data; 0 when `hit`=0.
- `irq`  out  1  interrupt to core `INT`; `irq = pending & ctrl.ie`.

## Operation
Register map (word offsets; `addr[1:0]` ignored; full-word writes only; unmapped offsets read 0 and ignore writes):
- 0x00 CTRL: bit0 `en`, bit1 `auto` (auto-reload), bit2 `ie` (irq enable); other bits read 0.
- 0x04 PRESET: reload value.
- 0x08 COUNT: read returns the live counter; a write loads the counter directly.
- 0x0C STATUS: bit0 `pending` (sticky); writing 1 to bit0 clears it, writing 0 has no effect.
- 0x10 PRESCALE: present only with `TIMER_PRESCALE_EN`.

Writes take effect when `we & hit` is high on a rising edge.

FSM states:
- IDLE: counter holds. A CTRL write with `en`=1 moves to LOAD.
- LOAD: `COUNT <= PRESET`, then move to CNT.
- CNT: if `COUNT == 0`, move to DONE. Otherwise, on each `tick`, `COUNT <= COUNT - 1`.
- DONE: set `pending <= 1`. If `auto`=1, move to LOAD. Otherwise clear `en` and move to IDLE.

Boundary and conflict rules:
- A CTRL write with `en`=0 in any state moves to IDLE on that edge. COUNT holds its value and `pending` is unchanged.
- A COUNT write in CNT overrides the decrement on that edge.
- A STATUS clear on the same edge as the DONE-state set leaves `pending`=1 (set wins).
- PRESET=0: the sequence is LOAD→CNT→DONE, with no decrement.
- The counter never wraps. Decrement occurs only while COUNT>0.
- A CTRL write with `en`=1 while already in LOAD/CNT/DONE does not restart the sequence. It only updates `auto`/`ie`.

Reset: state IDLE; CTRL, PRESET, COUNT, STATUS, and PRESCALE are all 0; the prescale counter is 0; `irq`=0. Reset asserted mid-count aborts immediately, with no pending set.

## Timing
- Reads are combinational, zero-latency, valid in the same cycle as `addr`. This is required for the single-cycle load path.
- With PRESET=N and tick every cycle, the enabling CTRL write occurs at edge 0. Then:
  - edge 1: COUNT=N, state CNT.
  - edge N+1: COUNT=0.
  - edge N+2: state DONE.
  - edge N+3: `pending`=1 and `irq` is high if `ie`=1.
- Auto-reload period is N+3 cycles between successive `pending` set edges.
- `irq` changes only via registered `pending`/`ie`. No glitch path from `addr`.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - PRESCALE at 0x10 (bits [15:0], reset 0), plus an internal 16-bit prescale counter.
  - `tick` is high when the prescale counter equals PRESCALE; the counter then returns to 0, otherwise it increments.
  - The prescale counter runs only in CNT and is cleared in LOAD.
  - PRESCALE=0 gives a tick every cycle. Decrement spacing is PRESCALE+1 cycles.
- Undefined: `tick`=1 always. Offset 0x10 reads 0 and ignores writes.

## Test plan
- Reset mid-count (PRESET=100, reset at COUNT=40): all registers 0, state IDLE, `irq`=0 immediately; no pending after release.
- PRESET=5, CTRL=0x5 written at edge 0: COUNT reads 5 at edge 1 and 0 at edge 6; `pending`=1 and `irq`=1 at edge 8; CTRL reads 0x4 afterwards.
- PRESET=3, CTRL=0x7: `pending` sets at edges 6, 12, 18 (STATUS cleared between them); each clear drops `irq` the next cycle.
- STATUS write 0x1 on the DONE edge: `pending` remains 1. COUNT write 0x20 during CNT: next read is 0x20 and the decrement resumes from there.
- `hit` decode: `addr`=BASE+0x20 with `we`=1 leaves all registers unchanged and `rdata`=0. `addr`=BASE+0x0B reads COUNT.
- With `TIMER_PRESCALE_EN`, PRESCALE=2, PRESET=4: COUNT decrements every 3 cycles; `pending` sets 3+4×3 edges after the enable write.
